ext_irq_ctrl: RTL
=================

Name: ext_irq_ctrl

Overview:
- Interrupt-source side of the external interrupt handshake consumed by the processor controller.
- Collects N_SRC asynchronous interrupt lines plus an internal periodic timer into a pending register and selects one winner by fixed priority.
- Drives ExtIRQ and holds it until ExtIAck completes a four-phase handshake.
- Exposes the winning source ID and pending/overrun status for the exception handler.

Parameters:
- N_SRC, 4, number of interrupt sources; index 0 has the highest priority.
- IDW, 2, width of irq_id; must equal ceil(log2(N_SRC)).
- TIMER_W, 16, width of the timer period and counter.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- irq_src  in  N_SRC  asynchronous interrupt lines; rising-edge triggered.
- irq_mask  in  N_SRC  1 = source enabled to request; masked sources still latch pending.
- timer_en  in  1  internal timer enable.
- timer_period  in  TIMER_W  timer period in clk cycles; 0 disables ticks.
- ovr_clr  in  1  one-cycle pulse; clears all overrun bits.
- ExtIAck  in  1  acknowledge from the processor controller.
- ExtIRQ  out  1  interrupt request, registered.
- irq_id  out  IDW  index of the source being requested, registered.
- pending  out  N_SRC  latched pending events.
- overrun  out  N_SRC  sticky flag: an event was lost.

Behaviour:
- Reset values: ExtIRQ=0, irq_id=0, pending=0, overrun=0, FSM=IDLE, timer counter=0, synchroniser and edge flops=0.
- Reset is asynchronous: ExtIRQ drops immediately on assertion, including mid-handshake.
- Input path per source: 2-flop synchroniser, then a previous-value flop; edge = sync & ~prev.
- Latency: pending[i] sets on the 3rd rising clk edge after irq_src[i] is first sampled high. ExtIRQ asserts on the next edge if the source is unmasked and FSM=IDLE.
- Timer:
  - timer_en=0 or timer_period=0: counter held at 0, no tick.
  - Otherwise the counter increments each cycle; at count==timer_period-1 it wraps to 0 and emits a one-cycle tick.
  - tick ORs into the edge of source 0.
- Pending update per bit:
  - Edge while pending=0 sets it.
  - Edge while pending=1 and not being cleared this cycle sets overrun[i].
  - Clear and edge in the same cycle on the same bit: pending stays 1, no overrun.
- Overrun: ovr_clr clears all bits. An overrun event in the same cycle as ovr_clr wins, so the bit is set.
- FSM:
  - IDLE: if (pending & irq_mask) != 0, capture the lowest set index into irq_id, set ExtIRQ=1, go to REQ.
  - REQ: ExtIRQ=1 and irq_id frozen; mask or pending changes are ignored. On ExtIAck=1: clear pending[irq_id], set ExtIRQ=0, go to ACKD.
  - ACKD: ExtIRQ=0. Wait for ExtIAck=0, then go to IDLE. A new request can assert no earlier than the edge after ExtIAck is sampled low.
- ExtIAck=1 while in IDLE is ignored.
- Masked pending bits remain pending. Unmasking later triggers a request from IDLE.

Test Plan:
- Reset, then a single pulse on irq_src[2] (mask=4'b1111) -> pending=4'b0100 at the 3rd edge, ExtIRQ=1 and irq_id=2 at the 4th. Assert ExtIAck -> next edge ExtIRQ=0 and pending=0. Drop ExtIAck -> IDLE.
- irq_src[1] and irq_src[3] rise together -> irq_id=1 first. After the handshake completes, a second request with irq_id=3.
- irq_mask=4'b0000, pulse irq_src[0] -> pending=4'b0001, ExtIRQ stays 0. Set mask=4'b0001 -> ExtIRQ=1, irq_id=0 one edge later.
- While in REQ with pending[2]=1, a second rising edge on irq_src[2] -> overrun[2]=1 and sticky. ovr_clr pulse -> overrun=0.
- timer_en=1, timer_period=5, mask=4'b0001 -> ExtIRQ with irq_id=0 every 5 cycles while acknowledged promptly. timer_period=0 -> no ticks.
- Assert reset while in REQ -> ExtIRQ=0 immediately (before the next clk edge), pending=0, FSM=IDLE.

Source files
------------

// File: rtl/ext_irq_ctrl.sv
// ext_irq_ctrl: edge-triggered interrupt collector with fixed priority and ExtIRQ/ExtIAck four-phase handshake
module ext_irq_ctrl #(
  parameter int N_SRC   = 4,
  parameter int IDW     = 2,
  parameter int TIMER_W = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N_SRC-1:0]   irq_src,
  input  logic [N_SRC-1:0]   irq_mask,
  input  logic               timer_en,
  input  logic [TIMER_W-1:0] timer_period,
  input  logic               ovr_clr,
  input  logic               ExtIAck,
  output logic               ExtIRQ,
  output logic [IDW-1:0]     irq_id,
  output logic [N_SRC-1:0]   pending,
  output logic [N_SRC-1:0]   overrun
);
  typedef enum logic [1:0] {IDLE, REQ, ACKD} state_t;
  state_t state, state_n;
  logic [N_SRC-1:0] s1, s2, prev, ev, clr, ovr_ev;
  logic [TIMER_W-1:0] cnt;
  logic t_on, tick, req;
  logic [IDW-1:0] low, id_n;
  assign t_on   = timer_en && timer_period != '0;
  assign tick   = t_on && cnt == timer_period - TIMER_W'(1);
  assign ev     = (s2 & ~prev) | {{(N_SRC-1){1'b0}}, tick};
  assign clr    = (state == REQ && ExtIAck) ? N_SRC'(1) << irq_id : '0;
  assign ovr_ev = ev & pending & ~clr;
  assign req    = |(pending & irq_mask);
  always_comb begin
    low = '0;
    for (int i = N_SRC - 1; i >= 0; i--)
      if (pending[i] && irq_mask[i]) low = IDW'(i);
  end
  always_comb begin
    state_n = state == IDLE ? (req ? REQ : IDLE) :
              state == REQ  ? (ExtIAck ? ACKD : REQ) :
                              (ExtIAck ? ACKD : IDLE);
    id_n    = (state == IDLE && req) ? low : irq_id;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1      <= '0;
      s2      <= '0;
      prev    <= '0;
      cnt     <= '0;
      pending <= '0;
      overrun <= '0;
      state   <= IDLE;
      ExtIRQ  <= 1'b0;
      irq_id  <= '0;
    end else begin
      s1      <= irq_src;
      s2      <= s1;
      prev    <= s2;
      cnt     <= (!t_on || tick) ? '0 : cnt + TIMER_W'(1);
      pending <= (pending & ~clr) | ev;
      overrun <= (ovr_clr ? '0 : overrun) | ovr_ev;
      state   <= state_n;
      ExtIRQ  <= state_n == REQ;
      irq_id  <= id_n;
    end
  end
endmodule
